// File: rtl/axi4_lite_slave_mem_responder.sv
// AXI4-Lite slave backed by a word-addressed register memory with independent
// write/read engines, programmable per-channel wait states and range/priv checks.

module axi4_lite_slave_mem_ready_gen #(
    parameter int WAIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAIT_WIDTH-1:0] wait_cfg,
    input  logic                  valid,
    input  logic                  enable,
    output logic                  ready
);
    logic [WAIT_WIDTH-1:0] cnt, wait_lat;

    // cnt holds how many cycles valid has been seen high; wait_lat freezes the
    // wait count for the duration of one wait phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready    <= (wait_cfg == '0);
            cnt      <= '0;
            wait_lat <= '0;
        end else if (ready && valid) begin
            ready <= 1'b0;
            cnt   <= '0;
        end else if (!enable) begin
            ready <= 1'b0;
            cnt   <= '0;
        end else if (!ready) begin
            if (wait_cfg == '0 && cnt == '0)
                ready <= 1'b1;
            else if (!valid)
                cnt <= '0;
            else if (cnt == '0) begin
                wait_lat <= wait_cfg;
                if (wait_cfg == WAIT_WIDTH'(1)) ready <= 1'b1;
                else                            cnt   <= WAIT_WIDTH'(1);
            end else if (cnt == wait_lat - WAIT_WIDTH'(1)) begin
                ready <= 1'b1;
                cnt   <= '0;
            end else
                cnt <= cnt + WAIT_WIDTH'(1);
        end
    end
endmodule

module axi4_lite_slave_mem_responder #(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter bit                     PRIV_ONLY     = 1'b0,
    parameter int                     WAIT_WIDTH    = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDRESS_WIDTH-1:0]  araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic [WAIT_WIDTH-1:0]     waitAw,
    input  logic [WAIT_WIDTH-1:0]     waitW,
    input  logic [WAIT_WIDTH-1:0]     waitB,
    input  logic [WAIT_WIDTH-1:0]     waitAr,
    input  logic [WAIT_WIDTH-1:0]     waitR
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] SPAN = ADDRESS_WIDTH'(MEM_DEPTH * STRB_W);
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_BWAIT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_RWAIT, RD_RESP} rd_state_t;

    function automatic logic [1:0] resp_of(input logic [ADDRESS_WIDTH-1:0] addr, input logic priv);
        if (addr < BASE_ADDRESS || addr - BASE_ADDRESS >= SPAN) return RESP_DECERR;
        if (PRIV_ONLY && !priv) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem;

    wr_state_t                wr_state, wr_next;
    logic                     aw_full, w_full, aw_priv;
    logic [ADDRESS_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0]    w_data;
    logic [STRB_W-1:0]        w_strb;
    logic [WAIT_WIDTH-1:0]    b_cnt, b_wait;
    logic [1:0]               wr_resp;
    logic [IDX_W-1:0]         aw_idx;
    logic                     aw_hs, w_hs, aw_en, w_en;

    rd_state_t                rd_state, rd_next;
    logic                     ar_priv, ld_priv, ar_hs, ar_en, ld_now;
    logic [ADDRESS_WIDTH-1:0] ar_addr, ld_addr;
    logic [WAIT_WIDTH-1:0]    r_cnt, r_wait;
    logic [1:0]               ld_resp;
    logic [IDX_W-1:0]         ld_idx;

    logic unused_prot;
    assign unused_prot = ^{awprot[2:1], arprot[2:1]};

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_resp = resp_of(aw_addr, aw_priv);
    assign aw_idx  = IDX_W'((aw_addr - BASE_ADDRESS) >> BYTE_SH);

    // Ready is re-armed on the same edge the engine goes back to idle, so
    // back-to-back transfers do not lose a cycle.
    assign aw_en = (wr_state == WR_IDLE && !aw_full) || (wr_state == WR_RESP && bready);
    assign w_en  = (wr_state == WR_IDLE && !w_full)  || (wr_state == WR_RESP && bready);
    assign ar_en = (rd_state == RD_IDLE) || (rd_state == RD_RESP && rready);

    axi4_lite_slave_mem_ready_gen #(.WAIT_WIDTH(WAIT_WIDTH)) u_aw_rdy (
        .clk(aclk), .rst_n(aresetn), .wait_cfg(waitAw), .valid(awvalid), .enable(aw_en), .ready(awready));
    axi4_lite_slave_mem_ready_gen #(.WAIT_WIDTH(WAIT_WIDTH)) u_w_rdy (
        .clk(aclk), .rst_n(aresetn), .wait_cfg(waitW), .valid(wvalid), .enable(w_en), .ready(wready));
    axi4_lite_slave_mem_ready_gen #(.WAIT_WIDTH(WAIT_WIDTH)) u_ar_rdy (
        .clk(aclk), .rst_n(aresetn), .wait_cfg(waitAr), .valid(arvalid), .enable(ar_en), .ready(arready));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wr_state <= WR_IDLE;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE:   if ((aw_full || aw_hs) && (w_full || w_hs)) wr_next = WR_COMMIT;
            WR_COMMIT: wr_next = (waitB == '0) ? WR_RESP : WR_BWAIT;
            WR_BWAIT:  if (b_cnt == b_wait - WAIT_WIDTH'(1)) wr_next = WR_RESP;
            WR_RESP:   if (bready) wr_next = WR_IDLE;
            default:   wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem     <= '0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            aw_priv <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            b_cnt   <= '0;
            b_wait  <= '0;
            bresp   <= RESP_OKAY;
            bvalid  <= 1'b0;
        end else begin
            bvalid <= (wr_next == WR_RESP);
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr;
                aw_priv <= awprot[0];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (wr_state == WR_COMMIT) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bresp   <= wr_resp;
                b_cnt   <= '0;
                b_wait  <= waitB;
                if (wr_resp == RESP_OKAY)
                    for (int i = 0; i < STRB_W; i++)
                        if (w_strb[i]) mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
            end else if (wr_state == WR_BWAIT)
                b_cnt <= b_cnt + WAIT_WIDTH'(1);
        end
    end

    // Zero-wait reads latch straight from the AR channel; delayed ones use the captured copy.
    assign ld_addr = (rd_state == RD_IDLE) ? araddr : ar_addr;
    assign ld_priv = (rd_state == RD_IDLE) ? arprot[0] : ar_priv;
    assign ld_resp = resp_of(ld_addr, ld_priv);
    assign ld_idx  = IDX_W'((ld_addr - BASE_ADDRESS) >> BYTE_SH);
    assign ld_now  = (rd_state != RD_RESP) && (rd_next == RD_RESP);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_state <= RD_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:  if (ar_hs) rd_next = (waitR == '0) ? RD_RESP : RD_RWAIT;
            RD_RWAIT: if (r_cnt == r_wait - WAIT_WIDTH'(1)) rd_next = RD_RESP;
            RD_RESP:  if (rready) rd_next = RD_IDLE;
            default:  rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_addr <= '0;
            ar_priv <= 1'b0;
            r_cnt   <= '0;
            r_wait  <= '0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            rvalid <= (rd_next == RD_RESP);
            if (ar_hs) begin
                ar_addr <= araddr;
                ar_priv <= arprot[0];
                r_cnt   <= '0;
                r_wait  <= waitR;
            end else if (rd_state == RD_RWAIT)
                r_cnt <= r_cnt + WAIT_WIDTH'(1);
            // mem is sampled before any same-edge commit lands, giving the pre-write value.
            if (ld_now) begin
                rresp <= ld_resp;
                rdata <= (ld_resp == RESP_OKAY) ? mem[ld_idx] : '0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave_mem_responder.sv
// Directed bench for the AXI4-Lite memory responder; expected responses are
// queued when a transfer is issued and popped when the DUT answers.

module tb_axi4_lite_slave_mem_responder;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [3:0]  wait_aw, wait_w, wait_b, wait_ar, wait_r;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [33:0] rexp;
    logic [1:0]  bexp;

    axi4_lite_slave_mem_responder #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
        .BASE_ADDRESS(32'h1000_0000), .PRIV_ONLY(1'b1), .WAIT_WIDTH(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .waitAw(wait_aw), .waitW(wait_w), .waitB(wait_b), .waitAr(wait_ar), .waitR(wait_r)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot, output int l);
        int n;
        logic aw_go, w_go;
        logic [1:0] e;
        awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while ((awvalid || wvalid) && n < 64) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        chk("aw_w_handshake", {awvalid, wvalid}, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 64) begin tick(); n++; end
        l = n + 1;
        chk("bvalid_seen", bvalid, 1'b1);
        e = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
        chk("bresp", bresp, e);
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot, output int l);
        int n;
        logic [33:0] e;
        araddr = addr; arprot = prot; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 64) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 64) begin tick(); n++; end
        l = n + 1;
        chk("rvalid_seen", rvalid, 1'b1);
        e = (rq.size() != 0) ? rq.pop_front() : 34'bx;
        chk("rresp", rresp, e[33:32]);
        chk("rdata", rdata, e[31:0]);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        wait_aw = 0; wait_w = 0; wait_b = 0; wait_ar = 0; wait_r = 0;
        do_reset();

        // Reset values with all waits zero
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        tick();

        // Basic write/read, zero-wait latencies
        bq.push_back(2'b00);
        axi_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b001, lat);
        chk("wr_latency", lat, 2);
        rq.push_back({2'b00, 32'hDEAD_BEEF});
        axi_read(32'h1000_0004, 3'b001, lat);
        chk("rd_latency", lat, 1);
        rq.push_back({2'b00, 32'hDEAD_BEEF});
        axi_read(32'h1000_0007, 3'b001, lat);

        // Partial strobes
        bq.push_back(2'b00);
        axi_write(32'h1000_0008, 32'hDEAD_BEEF, 4'hF, 3'b001, lat);
        bq.push_back(2'b00);
        axi_write(32'h1000_0008, 32'h0000_1234, 4'b0011, 3'b001, lat);
        rq.push_back({2'b00, 32'hDEAD_1234});
        axi_read(32'h1000_0008, 3'b001, lat);
        bq.push_back(2'b00);
        axi_write(32'h1000_0008, 32'hAB00_0000, 4'b1000, 3'b001, lat);
        rq.push_back({2'b00, 32'hABAD_1234});
        axi_read(32'h1000_0008, 3'b001, lat);

        // Out of range: write must not alias onto word 0
        bq.push_back(2'b11);
        axi_write(32'h1000_0040, 32'h5555_5555, 4'hF, 3'b001, lat);
        rq.push_back({2'b00, 32'h0});
        axi_read(32'h1000_0000, 3'b001, lat);
        rq.push_back({2'b11, 32'h0});
        axi_read(32'h1000_0040, 3'b001, lat);
        rq.push_back({2'b11, 32'h0});
        axi_read(32'h0FFF_FFFC, 3'b000, lat);

        // Unprivileged accesses
        rq.push_back({2'b10, 32'h0});
        axi_read(32'h1000_0004, 3'b000, lat);
        bq.push_back(2'b10);
        axi_write(32'h1000_0004, 32'h0000_0000, 4'hF, 3'b110, lat);
        rq.push_back({2'b00, 32'hDEAD_BEEF});
        axi_read(32'h1000_0004, 3'b001, lat);

        // W before AW with AW and B wait states
        wait_aw = 4'd2; wait_b = 4'd3;
        do_reset();
        chk("rst_awready_wait", awready, 1'b0);
        chk("rst_wready_nowait", wready, 1'b1);
        awaddr = 32'h1000_000C; awprot = 3'b001; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        bq.push_back(2'b00);
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wready_drop", wready, 1'b0);
        tick();
        tick();
        awvalid = 1'b1;
        tick();
        chk("awready_wait1", awready, 1'b0);
        tick();
        chk("awready_wait2", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 64) begin tick(); lat++; end
        chk("bwait_latency", lat + 1, 5);
        repeat (4) tick();
        chk("bvalid_hold", bvalid, 1'b1);
        bexp = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
        chk("bresp_hold", bresp, bexp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 1'b0);
        wait_aw = 0; wait_b = 0;
        tick();
        tick();
        rq.push_back({2'b00, 32'hCAFE_F00D});
        axi_read(32'h1000_000C, 3'b001, lat);

        // Same-word write commit and read latch on one edge
        bq.push_back(2'b00);
        axi_write(32'h1000_0010, 32'h1111_1111, 4'hF, 3'b001, lat);
        awaddr = 32'h1000_0010; awprot = 3'b001; wdata = 32'h2222_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        bq.push_back(2'b00);
        rq.push_back({2'b00, 32'h1111_1111});
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h1000_0010; arprot = 3'b001; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("coll_rvalid", rvalid, 1'b1);
        chk("coll_bvalid", bvalid, 1'b1);
        rexp = (rq.size() != 0) ? rq.pop_front() : 34'bx;
        chk("coll_rresp", rresp, rexp[33:32]);
        chk("coll_rdata", rdata, rexp[31:0]);
        bexp = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
        chk("coll_bresp", bresp, bexp);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        rq.push_back({2'b00, 32'h2222_2222});
        axi_read(32'h1000_0010, 3'b001, lat);

        // Reset while a read response is pending
        araddr = 32'h1000_0010; arprot = 3'b001; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("pre_rst_rvalid", rvalid, 1'b1);
        chk("pre_rst_rdata", rdata, 32'h2222_2222);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_rvalid", rvalid, 1'b0);
        chk("async_rst_rdata", rdata, 32'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("post_rst_arready", arready, 1'b1);
        chk("post_rst_rvalid", rvalid, 1'b0);
        tick();
        rq.push_back({2'b00, 32'h0});
        axi_read(32'h1000_0010, 3'b001, lat);
        chk("post_rst_rd_latency", lat, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_slave_mem_responder.md
# axi4_lite_slave_mem_responder

Parametrised AXI4-Lite slave with an internal word-addressed register memory, independent write and read engines, programmable per-channel wait states, byte strobes, and address/protection checking with OKAY/SLVERR/DECERR responses. It sits in the slave agent side of the AXI4-Lite environment as a synthesisable reference responder. It replaces fixed-behaviour slave models, generalising data width, memory depth, base address and access policy.

## Interface

- ADDRESS_WIDTH, 32, width of awaddr/araddr
- DATA_WIDTH, 32, 32 or 64; strobe width DATA_WIDTH/8
- MEM_DEPTH, 16, number of DATA_WIDTH words; power of two, ≥2
- BASE_ADDRESS, 0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8
- PRIV_ONLY, 0, 1 = accesses with prot[0]=0 get SLVERR
- WAIT_WIDTH, 4, width of wait-count config inputs

Ports (`aclk` is the single clock; `aresetn` is an asynchronous, active-low reset):
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- awaddr  in  ADDRESS_WIDTH, awprot  in  3, awvalid  in  1, awready  out  1
- wdata  in  DATA_WIDTH, wstrb  in  DATA_WIDTH/8, wvalid  in  1, wready  out  1
- bresp  out  2, bvalid  out  1, bready  in  1
- araddr  in  ADDRESS_WIDTH, arprot  in  3, arvalid  in  1, arready  out  1
- rdata  out  DATA_WIDTH, rresp  out  2, rvalid  out  1, rready  in  1
- waitAw, waitW, waitB, waitAr, waitR  in  WAIT_WIDTH  per-channel wait states, sampled at the start of each wait phase

## Operation

- Address decode: in range iff BASE_ADDRESS ≤ addr < BASE_ADDRESS + MEM_DEPTH*DATA_WIDTH/8. Word index = (addr − BASE_ADDRESS) >> log2(DATA_WIDTH/8); low byte bits ignored.
- Response priority: out of range → DECERR (2'b11); else PRIV_ONLY and prot[0]=0 → SLVERR (2'b10); else OKAY (2'b00). EXOKAY is never produced.
- Write engine states:
  - WR_IDLE: AW and W slots are captured independently, in either order or in the same cycle.
  - Once both slots hold a beat, the engine spends one WR_COMMIT cycle. A memory update occurs only on OKAY: byte lane i is written iff wstrb[i].
  - WR_BWAIT counts waitB cycles, then WR_RESP asserts bvalid. bvalid and bresp are held until bready, then the engine returns to WR_IDLE.
- Ready generation for AW and W: while its slot is empty and the channel's wait count is 0, ready is high. Otherwise ready rises after the corresponding valid has been observed high for waitAw/waitW cycles. Ready drops the cycle after its handshake and stays low until the engine returns to WR_IDLE.
- Read engine states:
  - RD_IDLE: arready follows the same rule as AW/W using waitAr.
  - On AR handshake, capture the address, then RD_RWAIT counts waitR cycles.
  - RD_RESP asserts rvalid with rdata/rresp held stable until rready, then returns to RD_IDLE.
  - rdata = memory word latched on entry to RD_RESP for OKAY; 0 for SLVERR/DECERR.
- Engines run concurrently. If a write commit and read-data latch hit the same word on the same edge, the read returns the pre-write value.
- Valid deasserted before handshake: the wait counter restarts from 0 on the next valid.

## Timing

- Reset values: awready/wready/arready = 1 if their wait input is 0 at reset release, else 0; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0; memory cleared to 0; all FSMs in IDLE; counters 0.
- Reset asserted mid-transaction: all outputs return to reset values immediately, with no response for the in-flight transfer.
- All outputs are registered; there is no combinational valid→ready path.
- Write latency, all waits 0 (AW and W together at edge T): commit at T+1, bvalid high at T+2.
- Write latency, general: bvalid rises waitB+2 cycles after the later of the AW/W handshakes.
- Read latency, waits 0 (AR handshake at T): rvalid high at T+1. General: T+1+waitR.
- Throughput: with zero waits and bready/rready held high, one write per 3 cycles and one read per 2 cycles.

## Test plan

- Reset release, all waits 0: awready=wready=arready=1, bvalid=rvalid=0. Write 0x1000_0004 ← 0xDEADBEEF with wstrb=4'hF. Required: bresp=OKAY at T+2, then a read of 0x1000_0004 returns 0xDEADBEEF/OKAY (BASE_ADDRESS=0x1000_0000).
- Partial strobe: preload 0xDEADBEEF, write 0x0000_1234 with wstrb=4'b0011. Required: read back 0xDEAD1234.
- Out of range and protection:
  - Write to BASE_ADDRESS+0x40 (MEM_DEPTH=16, 32-bit) → bresp=DECERR, memory unchanged.
  - With PRIV_ONLY=1, read with arprot=3'b000 → rresp=SLVERR, rdata=0.
- W before AW: wvalid 3 cycles before awvalid, waitAw=2, waitB=3. Required: awready rises 2 cycles after awvalid, bvalid 5 cycles after the AW handshake, and bvalid holds 4 cycles with bready low.
- Concurrent same-address: word holds 0x11111111. Align the write commit with the read-data latch of the same word while writing 0x22222222. Required: read returns 0x11111111, and a subsequent read returns 0x22222222.
- Reset mid-read: drop aresetn while rvalid=1. Required: rvalid=0 asynchronously, memory reads 0 after release, and the read FSM is in RD_IDLE.
